// File: rtl/gbe_cpu_pkg.sv
// gbe_cpu_pkg: register indices, address regions, IRQ bit positions and lane-merge helper for the CPU ring attach
package gbe_cpu_pkg;
    localparam logic [1:0] REGION_REG = 2'd0;
    localparam logic [1:0] REGION_TX  = 2'd1;
    localparam logic [1:0] REGION_RX  = 2'd2;
    localparam logic [1:0] REGION_ARP = 2'd3;
    localparam logic [3:0] REG_MAC_HI    = 4'd0;
    localparam logic [3:0] REG_MAC_LO    = 4'd1;
    localparam logic [3:0] REG_GATEWAY   = 4'd3;
    localparam logic [3:0] REG_IP        = 4'd4;
    localparam logic [3:0] REG_BUF       = 4'd6;
    localparam logic [3:0] REG_PORT      = 4'd8;
    localparam logic [3:0] REG_PHY_STAT  = 4'd9;
    localparam logic [3:0] REG_PHY_CTRL  = 4'd10;
    localparam logic [3:0] REG_IRQ_STAT  = 4'd11;
    localparam logic [3:0] REG_IRQ_MASK  = 4'd12;
    localparam logic [3:0] REG_QUEUE     = 4'd13;
    localparam logic [3:0] REG_TX_CNT    = 4'd14;
    localparam logic [3:0] REG_RX_CNT    = 4'd15;
    localparam int IRQ_RX_RISE = 0;
    localparam int IRQ_TX_DONE = 1;
    localparam int IRQ_TX_OVF  = 2;
    typedef enum logic [1:0] {ST_IDLE, ST_RMW, ST_ACK} wb_state_t;
    function automatic logic [31:0] lane_merge(input logic [31:0] old_d, input logic [31:0] new_d, input logic [3:0] sel);
        logic [31:0] m;
        m = old_d;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = sel[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
        return m;
    endfunction
endpackage

// File: rtl/gbe_tx_slot_queue.sv
// gbe_tx_slot_queue: circular queue of committed {slot, size} TX packets plus the slot being filled
// Ports: i_push/i_size commit the fill slot, i_pop retires the head; o_head_* describe the head,
// o_fill_slot/o_count/o_full/o_empty give queue state, o_overflow/o_popped are one-cycle event pulses.
module gbe_tx_slot_queue #(
    parameter int SLOTS_LOG2 = 1,
    parameter int SIZE_W = 12,
    localparam int SLOT_W = SLOTS_LOG2 > 0 ? SLOTS_LOG2 : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [SIZE_W-1:0] i_size,
    input  logic              i_pop,
    output logic [SLOT_W-1:0] o_head_slot,
    output logic [SIZE_W-1:0] o_head_size,
    output logic [SLOT_W-1:0] o_fill_slot,
    output logic [3:0]        o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow,
    output logic              o_popped
);
    localparam int DEPTH = 1 << SLOTS_LOG2;
    // Slots are filled and retired in order, so the write pointer is the fill slot
    // and the read pointer is the head slot; only sizes need storing.
    logic [SIZE_W-1:0] r_size [DEPTH];
    logic [SLOT_W-1:0] r_wr, r_rd;
    logic [3:0]        r_count;
    logic              w_push, w_pop;
    function automatic logic [SLOT_W-1:0] inc(input logic [SLOT_W-1:0] p);
        return (p == SLOT_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign o_full      = r_count == 4'(DEPTH);
    assign o_empty     = r_count == 4'd0;
    assign w_pop       = i_pop & !o_empty;
    assign w_push      = i_push & (!o_full | w_pop);
    assign o_overflow  = i_push & !w_push;
    assign o_popped    = w_pop;
    assign o_head_slot = r_rd;
    assign o_head_size = r_size[r_rd];
    assign o_fill_slot = r_wr;
    assign o_count     = r_count;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_size[r_wr] <= i_size;
            r_wr    <= w_push ? inc(r_wr) : r_wr;
            r_rd    <= w_pop ? inc(r_rd) : r_rd;
            r_count <= r_count + {3'b0, w_push} - {3'b0, w_pop};
        end
    end
endmodule

// File: rtl/gbe_cpu_ring_attach.sv
// gbe_cpu_ring_attach: Wishbone slave giving the CPU access to UDP core config, ARP cache, RX/TX buffers and PHY
// Ports: wb_* Wishbone slave; local_* core configuration; arp_cache_* ARP RAM port; cpu_rx_* RX buffer and
// handshake; cpu_tx_* TX buffer port and committed-packet queue head; phy_* PHY status/control; irq_o interrupt.
module gbe_cpu_ring_attach
    import gbe_cpu_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC     = 48'hffff_ffff_ffff,
    parameter logic [31:0] LOCAL_IP      = 32'hffff_ffff,
    parameter logic [15:0] LOCAL_PORT    = 16'hffff,
    parameter logic [7:0]  LOCAL_GATEWAY = 8'd0,
    parameter logic        LOCAL_ENABLE  = 1'b0,
    parameter logic [31:0] PHY_CONFIG    = 32'd0,
    parameter int          BUF_AW        = 9,
    parameter int          TX_SLOTS_LOG2 = 1,
    parameter int          ARP_AW        = 8,
    localparam int         SIZE_W        = BUF_AW + 3,
    localparam int         SLOT_W        = TX_SLOTS_LOG2 > 0 ? TX_SLOTS_LOG2 : 1
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    input  logic                            wb_stb_i,
    input  logic                            wb_cyc_i,
    input  logic                            wb_we_i,
    input  logic [31:0]                     wb_adr_i,
    input  logic [31:0]                     wb_dat_i,
    input  logic [3:0]                      wb_sel_i,
    output logic [31:0]                     wb_dat_o,
    output logic                            wb_ack_o,
    output logic                            wb_err_o,
    output logic                            local_enable,
    output logic [47:0]                     local_mac,
    output logic [31:0]                     local_ip,
    output logic [15:0]                     local_port,
    output logic [7:0]                      local_gateway,
    output logic [ARP_AW-1:0]               arp_cache_addr,
    input  logic [47:0]                     arp_cache_rd_data,
    output logic [47:0]                     arp_cache_wr_data,
    output logic                            arp_cache_wr_en,
    output logic [BUF_AW-1:0]               cpu_rx_buffer_addr,
    input  logic [31:0]                     cpu_rx_buffer_rd_data,
    input  logic [SIZE_W-1:0]               cpu_rx_size,
    input  logic                            cpu_rx_ready,
    output logic                            cpu_rx_ack,
    output logic [TX_SLOTS_LOG2+BUF_AW-1:0] cpu_tx_buffer_addr,
    input  logic [31:0]                     cpu_tx_buffer_rd_data,
    output logic [31:0]                     cpu_tx_buffer_wr_data,
    output logic                            cpu_tx_buffer_wr_en,
    output logic                            cpu_tx_ready,
    output logic [SLOT_W-1:0]               cpu_tx_slot,
    output logic [SIZE_W-1:0]               cpu_tx_size,
    input  logic                            cpu_tx_done,
    input  logic [31:0]                     phy_status,
    output logic [31:0]                     phy_control,
    output logic                            irq_o
);
    wb_state_t          r_state, w_next;
    logic               r_ack, r_rx_ack, r_rx_ready_d, r_irq, r_en;
    logic [47:0]        r_mac, r_wdata, w_merge;
    logic [31:0]        r_ip, r_phy, r_rdat, r_txcnt, r_rxcnt, w_rd_reg, w_buf_rd, w_lo, w_hi;
    logic [15:0]        r_port;
    logic [7:0]         r_gw;
    logic [2:0]         r_status, r_mask, w_irq_set, w_w1c;
    logic [SIZE_W-1:0]  r_tx_size;
    logic [SLOT_W-1:0]  w_fill;
    logic [3:0]         w_count, w_idx;
    logic [1:0]         w_region;
    logic               w_full, w_empty, w_ovf, w_popped;
    logic               w_idle_req, w_rmw, w_reg_wr, w_commit, w_rx_set;
    logic [SLOT_W+BUF_AW-1:0] w_tx_addr;
    logic               w_unused;
    assign w_region   = wb_adr_i[13:12];
    assign w_idx      = wb_adr_i[5:2];
    assign w_idle_req = wb_stb_i & wb_cyc_i & !wb_ack_o & (r_state == ST_IDLE);
    assign w_rmw      = wb_we_i & (w_region == REGION_TX || w_region == REGION_ARP);
    assign w_reg_wr   = w_idle_req & wb_we_i & (w_region == REGION_REG);
    assign w_commit   = w_reg_wr & (w_idx == REG_BUF) & wb_sel_i[2];
    assign w_rx_set   = w_reg_wr & (w_idx == REG_BUF) & wb_sel_i[0] & (wb_dat_i[7:0] == 8'd0);
    assign w_w1c      = (w_reg_wr && w_idx == REG_IRQ_STAT) ? wb_dat_i[2:0] : 3'b0;
    assign w_tx_addr  = {w_fill, wb_adr_i[BUF_AW+1:2]};
    assign w_unused   = &{1'b0, wb_adr_i, w_tx_addr, w_hi[31:16]};
    gbe_tx_slot_queue #(.SLOTS_LOG2(TX_SLOTS_LOG2), .SIZE_W(SIZE_W)) u_queue (
        .i_clk      (wb_clk_i),
        .i_rst      (wb_rst_i),
        .i_push     (w_commit),
        .i_size     (wb_dat_i[16 +: SIZE_W]),
        .i_pop      (cpu_tx_done),
        .o_head_slot(cpu_tx_slot),
        .o_head_size(cpu_tx_size),
        .o_fill_slot(w_fill),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_overflow (w_ovf),
        .o_popped   (w_popped)
    );
    assign wb_ack_o              = r_ack | (r_state == ST_ACK);
    assign wb_err_o              = 1'b0;
    assign local_enable          = r_en;
    assign local_mac             = r_mac;
    assign local_ip              = r_ip;
    assign local_port            = r_port;
    assign local_gateway         = r_gw;
    assign phy_control           = r_phy;
    assign irq_o                 = r_irq;
    assign cpu_rx_ack            = r_rx_ack;
    assign cpu_tx_ready          = !w_empty;
    assign arp_cache_addr        = wb_adr_i[ARP_AW+2:3];
    assign cpu_rx_buffer_addr    = wb_adr_i[BUF_AW+1:2];
    assign cpu_tx_buffer_addr    = w_tx_addr[TX_SLOTS_LOG2+BUF_AW-1:0];
    assign cpu_tx_buffer_wr_data = r_wdata[31:0];
    assign arp_cache_wr_data     = r_wdata;
    // ARP entries are 48 bits: adr[2] picks the low word or the 16-bit high half (lanes 0-1 only).
    assign w_lo = lane_merge(w_region == REGION_TX ? cpu_tx_buffer_rd_data : arp_cache_rd_data[31:0], wb_dat_i, wb_sel_i);
    assign w_hi = lane_merge({16'b0, arp_cache_rd_data[47:32]}, wb_dat_i, wb_sel_i & 4'b0011);
    assign w_merge = (w_region == REGION_ARP && !wb_adr_i[2]) ? {w_hi[15:0], arp_cache_rd_data[31:0]}
                                                              : {arp_cache_rd_data[47:32], w_lo};
    assign wb_dat_o = w_region == REGION_REG ? r_rdat :
                      w_region == REGION_TX  ? cpu_tx_buffer_rd_data :
                      w_region == REGION_RX  ? cpu_rx_buffer_rd_data :
                      wb_adr_i[2]            ? arp_cache_rd_data[31:0] : {16'b0, arp_cache_rd_data[47:32]};
    always_comb begin
        w_next = r_state == ST_RMW ? ST_ACK : ST_IDLE;
        if (w_idle_req && w_rmw) w_next = ST_RMW;
        cpu_tx_buffer_wr_en = (r_state == ST_ACK) && (w_region == REGION_TX);
        arp_cache_wr_en     = (r_state == ST_ACK) && (w_region == REGION_ARP);
        w_irq_set = '0;
        w_irq_set[IRQ_RX_RISE] = cpu_rx_ready & !r_rx_ready_d;
        w_irq_set[IRQ_TX_DONE] = w_popped;
        w_irq_set[IRQ_TX_OVF]  = w_ovf;
    end
    always_comb begin
        w_buf_rd = '0;
        w_buf_rd[16 +: SIZE_W] = r_tx_size;
        w_buf_rd[SIZE_W-1:0] = r_rx_ack ? '0 : cpu_rx_size;
        case (w_idx)
            REG_MAC_HI:   w_rd_reg = {16'b0, r_mac[47:32]};
            REG_MAC_LO:   w_rd_reg = r_mac[31:0];
            REG_GATEWAY:  w_rd_reg = {24'b0, r_gw};
            REG_IP:       w_rd_reg = r_ip;
            REG_BUF:      w_rd_reg = w_buf_rd;
            REG_PORT:     w_rd_reg = {15'b0, r_en, r_port};
            REG_PHY_STAT: w_rd_reg = phy_status;
            REG_PHY_CTRL: w_rd_reg = r_phy;
            REG_IRQ_STAT: w_rd_reg = {29'b0, r_status};
            REG_IRQ_MASK: w_rd_reg = {29'b0, r_mask};
            REG_QUEUE:    w_rd_reg = {14'b0, w_empty, w_full, 5'b0, 3'(w_fill), 4'b0, w_count};
            REG_TX_CNT:   w_rd_reg = r_txcnt;
            REG_RX_CNT:   w_rd_reg = r_rxcnt;
            default:      w_rd_reg = '0;
        endcase
    end
    always_ff @(posedge wb_clk_i) begin
        r_state <= wb_rst_i ? ST_IDLE : w_next;
    end
    always_ff @(posedge wb_clk_i) begin
        if (w_idle_req) r_rdat <= w_rd_reg;
        if (r_state == ST_RMW) r_wdata <= w_merge;
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack        <= 1'b0;
            r_rx_ack     <= 1'b0;
            r_rx_ready_d <= 1'b0;
            r_irq        <= 1'b0;
            r_mac        <= LOCAL_MAC;
            r_ip         <= LOCAL_IP;
            r_port       <= LOCAL_PORT;
            r_gw         <= LOCAL_GATEWAY;
            r_en         <= LOCAL_ENABLE;
            r_phy        <= PHY_CONFIG;
            r_tx_size    <= '0;
            r_status     <= '0;
            r_mask       <= '0;
            r_txcnt      <= '0;
            r_rxcnt      <= '0;
        end else begin
            r_ack        <= w_idle_req & !w_rmw;
            r_rx_ready_d <= cpu_rx_ready;
            // rx_ack stays up until the core drops rx_ready
            r_rx_ack     <= w_rx_set | (r_rx_ack & cpu_rx_ready);
            r_irq        <= |(r_status & r_mask);
            r_status     <= (r_status & ~w_w1c) | w_irq_set;
            r_txcnt      <= (w_reg_wr && w_idx == REG_TX_CNT) ? '0 : r_txcnt + 32'(w_popped & ~&r_txcnt);
            r_rxcnt      <= (w_reg_wr && w_idx == REG_RX_CNT) ? '0 : r_rxcnt + 32'(w_irq_set[IRQ_RX_RISE] & ~&r_rxcnt);
            if (w_reg_wr) begin
                case (w_idx)
                    REG_MAC_HI:   r_mac[47:32] <= wb_dat_i[15:0];
                    REG_MAC_LO:   r_mac[31:0] <= wb_dat_i;
                    REG_GATEWAY:  r_gw <= wb_dat_i[7:0];
                    REG_IP:       r_ip <= wb_dat_i;
                    REG_BUF:      r_tx_size <= wb_sel_i[2] ? wb_dat_i[16 +: SIZE_W] : r_tx_size;
                    REG_PORT:     {r_en, r_port} <= wb_dat_i[16:0];
                    REG_PHY_CTRL: r_phy <= lane_merge(r_phy, wb_dat_i, wb_sel_i);
                    REG_IRQ_MASK: r_mask <= wb_dat_i[2:0];
                    default:      r_mask <= r_mask;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gbe_cpu_ring_attach.sv
// tb_gbe_cpu_ring_attach: directed self-checking bench for gbe_cpu_ring_attach with behavioural RAMs
module tb_gbe_cpu_ring_attach;
    logic        clk = 1'b0, rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat = '0, dat_o;
    logic [3:0]  sel = '0;
    logic        ack, err, l_en, arp_we, rx_ack, tx_we, tx_ready, irq;
    logic [47:0] l_mac, arp_rd, arp_wd, arp_wd_seen;
    logic [31:0] l_ip, rx_rd, tx_rd, tx_wd, phy_ctl;
    logic [15:0] l_port;
    logic [7:0]  l_gw, arp_addr;
    logic [8:0]  rx_addr;
    logic [9:0]  tx_addr;
    logic [11:0] rx_size = 12'd100, tx_size;
    logic        rx_ready = 1'b0, tx_done = 1'b0;
    logic [0:0]  tx_slot;
    logic [31:0] phy_stat = 32'hdead_beef;
    logic [31:0] tx_mem [1024];
    logic [31:0] rx_mem [512];
    logic [47:0] arp_mem [256];
    int n_cmp = 0, n_bad = 0;
    logic [31:0] rd;
    int lat;

    gbe_cpu_ring_attach #(
        .LOCAL_MAC(48'h0102_0304_0506), .LOCAL_IP(32'h0a00_0001), .LOCAL_PORT(16'd10000),
        .LOCAL_GATEWAY(8'd1), .LOCAL_ENABLE(1'b1), .PHY_CONFIG(32'h1122_3344)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err),
        .local_enable(l_en), .local_mac(l_mac), .local_ip(l_ip), .local_port(l_port), .local_gateway(l_gw),
        .arp_cache_addr(arp_addr), .arp_cache_rd_data(arp_rd), .arp_cache_wr_data(arp_wd), .arp_cache_wr_en(arp_we),
        .cpu_rx_buffer_addr(rx_addr), .cpu_rx_buffer_rd_data(rx_rd), .cpu_rx_size(rx_size),
        .cpu_rx_ready(rx_ready), .cpu_rx_ack(rx_ack),
        .cpu_tx_buffer_addr(tx_addr), .cpu_tx_buffer_rd_data(tx_rd), .cpu_tx_buffer_wr_data(tx_wd),
        .cpu_tx_buffer_wr_en(tx_we), .cpu_tx_ready(tx_ready), .cpu_tx_slot(tx_slot), .cpu_tx_size(tx_size),
        .cpu_tx_done(tx_done), .phy_status(phy_stat), .phy_control(phy_ctl), .irq_o(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            tx_mem[5]  <= 32'h1122_3344;
            rx_mem[7]  <= 32'hcafe_f00d;
            arp_mem[3] <= 48'haaaa_1234_5678;
        end
        tx_rd  <= tx_mem[tx_addr];
        rx_rd  <= rx_mem[rx_addr];
        arp_rd <= arp_mem[arp_addr];
        if (tx_we) tx_mem[tx_addr] <= tx_wd;
        if (arp_we) begin
            arp_mem[arp_addr] <= arp_wd;
            arp_wd_seen <= arp_wd;
        end
    end

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] r, output int l);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
        l = 0; r = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                l = i;
                r = dat_o;
                break;
            end
        end
        if (l == 0) check("ack_timeout", 48'd0, 48'd1);
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        wb_xfer(1'b1, a, d, s, r, lat);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, a, 32'd0, 4'hf, r, lat);
        check(tag, r, exp);
    endtask

    task automatic done_pulse;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_irq", irq, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_err", err, 0);
        check("rst_rx_ack", rx_ack, 0);
        check("rst_phy_ctl", phy_ctl, 32'h1122_3344);
        rd_chk("reg0_mac_hi", 32'h00, 32'h0000_0102);
        check("reg_read_lat", lat, 1);
        rd_chk("reg1_mac_lo", 32'h04, 32'h0304_0506);
        rd_chk("reg3_gw", 32'h0c, 32'h0000_0001);
        rd_chk("reg4_ip", 32'h10, 32'h0a00_0001);
        rd_chk("reg8_port", 32'h20, 32'h0001_2710);
        rd_chk("reg9_phy_stat", 32'h24, 32'hdead_beef);
        rd_chk("reg2_unmapped", 32'h08, 32'h0);
        rd_chk("reg13_reset", 32'h34, 32'h0002_0000);

        wr(32'h1014, 32'h0000_ab00, 4'b0010);
        check("tx_rmw_lat", lat, 2);
        check("tx_rmw_mem", tx_mem[5], 32'h1122_ab44);
        rd_chk("tx_readback", 32'h1014, 32'h1122_ab44);
        check("mem_read_lat", lat, 1);

        wr(32'h3018, 32'h0000_beef, 4'b0011);
        check("arp_rmw_lat", lat, 2);
        check("arp_wr_data", arp_wd_seen, 48'hbeef_1234_5678);
        rd_chk("arp_hi_read", 32'h3018, 32'h0000_beef);
        rd_chk("arp_lo_read", 32'h301c, 32'h1234_5678);
        rd_chk("rx_buf_read", 32'h201c, 32'hcafe_f00d);

        wr(32'h18, 32'h0040_0000, 4'b0100);
        check("commit1_ready", tx_ready, 1);
        check("commit1_slot", tx_slot, 0);
        wr(32'h18, 32'h0040_0000, 4'b0100);
        check("commit2_size", tx_size, 64);
        rd_chk("queue_full", 32'h34, 32'h0001_0002);
        wr(32'h18, 32'h0040_0000, 4'b0100);
        rd_chk("ovf_status", 32'h2c, 32'h0000_0004);
        rd_chk("queue_after_ovf", 32'h34, 32'h0001_0002);
        done_pulse();
        check("done_slot", tx_slot, 1);
        check("done_size", tx_size, 64);
        rd_chk("tx_cnt_1", 32'h38, 32'h1);
        rd_chk("status_done", 32'h2c, 32'h0000_0006);
        rd_chk("queue_one", 32'h34, 32'h0000_0001);
        done_pulse();
        done_pulse();
        check("drained_ready", tx_ready, 0);
        rd_chk("tx_cnt_2", 32'h38, 32'h2);
        rd_chk("queue_empty", 32'h34, 32'h0002_0000);
        wr(32'h38, 32'h0, 4'hf);
        rd_chk("tx_cnt_clear", 32'h38, 32'h0);
        wr(32'h2c, 32'h7, 4'hf);
        rd_chk("status_w1c", 32'h2c, 32'h0);

        wr(32'h30, 32'h1, 4'hf);
        check("irq_masked_idle", irq, 0);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        check("irq_one_cycle", irq, 0);
        @(posedge clk); #1;
        check("irq_two_cycles", irq, 1);
        rd_chk("rx_cnt_1", 32'h3c, 32'h1);
        wr(32'h2c, 32'h1, 4'hf);
        check("irq_cleared", irq, 0);
        rd_chk("rx_size_read", 32'h18, 32'h0040_0064);
        wr(32'h18, 32'h0, 4'b0001);
        check("rx_ack_set", rx_ack, 1);
        rd_chk("rx_size_acked", 32'h18, 32'h0040_0000);
        repeat (2) @(posedge clk);
        #1 check("rx_ack_held", rx_ack, 1);
        rx_ready = 1'b0;
        @(posedge clk); #1;
        check("rx_ack_clear", rx_ack, 0);
        rd_chk("rx_size_again", 32'h18, 32'h0040_0064);

        wr(32'h28, 32'h0055_0000, 4'b0100);
        check("phy_lane2", phy_ctl, 32'h1155_3344);
        rd_chk("phy_readback", 32'h28, 32'h1155_3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gbe_cpu_ring_attach.md
# gbe_cpu_ring_attach

Wishbone slave that gives the PowerPC access to a GbE/10GbE UDP core: local MAC/IP/port/gateway configuration, ARP cache, RX buffer and PHY control/status. This is the parametrised successor of the single-buffer CPU attach. It generalises buffer depth, ARP depth and TX slot count, and adds:
- a committed-TX-packet queue,
- a maskable interrupt,
- packet counters,
- per-byte-lane PHY control writes.

It sits between the OPB/Wishbone bridge and the UDP wrapper's buffer RAMs.

## Interface
- LOCAL_MAC, 48'hffff_ffff_ffff, reset MAC
- LOCAL_IP, 32'hffff_ffff, reset IP
- LOCAL_PORT, 16'hffff, reset UDP port
- LOCAL_GATEWAY, 8'd0, reset gateway (last IP octet)
- LOCAL_ENABLE, 0, reset core enable
- PHY_CONFIG, 32'd0, reset phy_control
- BUF_AW, 9, word-address width of one packet slot (legal range 6..10)
- TX_SLOTS_LOG2, 1, log2 of the TX slot count (legal range 0..3)
- ARP_AW, 8, ARP cache address width (legal range 1..8)
- SIZE_W is derived as BUF_AW+3 (byte-count width)

Ports, clock and reset first:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous, active-high reset
- wb_stb_i, wb_cyc_i, wb_we_i  in  1  Wishbone control
- wb_adr_i  in  32  byte address; only [13:0] is decoded
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte lanes
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  tied to 0
- local_enable / local_mac / local_ip / local_port / local_gateway  out  1/48/32/16/8  configuration
- arp_cache_addr  out  ARP_AW  ARP cache address
- arp_cache_rd_data  in  48  ARP cache read data
- arp_cache_wr_data  out  48  ARP cache write data
- arp_cache_wr_en  out  1  ARP cache write enable
- cpu_rx_buffer_addr  out  BUF_AW  RX buffer word address
- cpu_rx_buffer_rd_data  in  32  RX buffer read data
- cpu_rx_size  in  SIZE_W  received byte count
- cpu_rx_ready  in  1  RX packet available
- cpu_rx_ack  out  1  RX packet consumed
- cpu_tx_buffer_addr  out  TX_SLOTS_LOG2+BUF_AW  address as {slot, word}
- cpu_tx_buffer_rd_data  in  32  TX buffer read data
- cpu_tx_buffer_wr_data  out  32  TX buffer write data
- cpu_tx_buffer_wr_en  out  1  TX buffer write enable
- cpu_tx_ready  out  1  queue not empty
- cpu_tx_slot  out  TX_SLOTS_LOG2 (min 1)  slot at queue head
- cpu_tx_size  out  SIZE_W  byte count of queue head
- cpu_tx_done  in  1  one-cycle pulse: head packet sent
- phy_status  in  32  PHY status
- phy_control  out  32  PHY control
- irq_o  out  1  registered interrupt

## Operation
- Region is selected by adr[13:12]: 0 registers (word = adr[5:2]), 1 TX slot being filled (word = adr[BUF_AW+1:2]), 2 RX buffer, 3 ARP (entry = adr[ARP_AW+2:3]; adr[2]=1 selects bits [31:0], adr[2]=0 selects {16'b0, [47:32]}).
- Register map, by word index:
  - 0: MAC[47:32] in bits [15:0]
  - 1: MAC[31:0]
  - 3: gateway
  - 4: IP
  - 6: bits [SIZE_W-1:0] read rx size, reading 0 while rx_ack is set; writing lane0 = 0 sets rx_ack. Bits [16+SIZE_W-1:16] hold tx size; a lane-2 write commits the current fill slot.
  - 8: {enable in bit16, port in [15:0]}
  - 9: phy_status (read-only)
  - 10: phy_control, each lane writes its own byte
  - 11: IRQ status, W1C: bit0 rx_ready rise, bit1 tx_done, bit2 tx_overflow
  - 12: IRQ mask, reset 0
  - 13: queue status: [3:0] count, [10:8] fill slot, bit16 full, bit17 empty
  - 14: TX packet counter
  - 15: RX packet counter. Writing either counter clears it. Counters are 32-bit and saturate.
  - Unmapped indices read 0 and ignore writes.
- TX queue: a circular FIFO of {slot, size} entries with depth 2^TX_SLOTS_LOG2.
  - Commit pushes {fill_slot, size} and advances fill_slot modulo the slot count.
  - A commit while the queue is full is dropped and sets status bit2; fill_slot is not advanced.
  - cpu_tx_done pops the head and increments the TX counter.
  - A simultaneous commit and done both take effect; the count is unchanged.
  - cpu_tx_done while the queue is empty is ignored.
- RX: cpu_rx_ack is held until cpu_rx_ready falls, then clears. A rising edge on cpu_rx_ready sets status bit0 and increments the RX counter.
- irq_o is registered as |(status & mask), so it updates one cycle after the status or mask changes.
- Reset values: config registers take their parameters; phy_control = PHY_CONFIG; queue empty; fill_slot 0; status, mask and counters 0; cpu_rx_ack, cpu_tx_ready, wr_en, wb_ack_o and irq_o all 0.

## Timing
- A transaction is stb & cyc & !ack.
- Reads and register writes: wb_ack_o is asserted one cycle after the request. Memory read data comes from the synchronous RAM and is aligned with ack, because the RAM address is driven combinationally from wb_adr_i.
- TX-buffer and ARP writes use a read-modify-write sequence IDLE→RMW→ACK:
  - RMW cycle: merge the selected lanes with the RAM read data.
  - ACK cycle: assert wr_en and wb_ack_o together for one cycle.
  - Ack is therefore 2 cycles after the request.
- Register side effects (commit, W1C, counter clear) occur at the same edge that raises ack.
- Reset mid-RMW aborts the sequence without asserting wr_en. A pending cpu_tx_done in the reset cycle is lost.

## Structure
- Package gbe_cpu_pkg holds the register index constants, region codes, and IRQ bit positions.
- Sub-module gbe_tx_slot_queue contains the FIFO of {slot, size}, fill_slot, and the full/empty/overflow logic.

## Test plan
- Reset, then read regs 0/1/4/8 → parameter values; irq_o=0; cpu_tx_ready=0.
- TX_SLOTS_LOG2=1: write 0x0040_0000 to reg 6 twice, then a third time → slots 0,1 queued, cpu_tx_size=64, cpu_tx_slot=0, status bit2 set on the third write. Pulse done → cpu_tx_slot=1; reg 14=1.
- Byte write sel=0010 of 0x0000AB00 to TX word 5 holding 0x11223344 → RAM holds 0x1122AB44; ack arrives 2 cycles after the request.
- ARP write 0x0000BEEF at entry 3, adr[2]=0 → arp_cache_wr_data[47:32]=BEEF with [31:0] preserved; readback returns 0x0000BEEF.
- Mask=1, raise cpu_rx_ready → irq_o=1 two cycles later. Write 1 to reg 11 bit0 → irq_o=0. Write reg 6 lane0=0 → rx_ack=1 and size reads 0; drop rx_ready → rx_ack=0.
- Write sel=0100 of 0x00550000 to reg 10 → phy_control = PHY_CONFIG with byte 2 = 0x55.
